// File: rtl/pipelined_addsub.sv
// pipelined_addsub: chunked add/subtract pipeline with registered inter-chunk carry, valid/ready flow control and flags
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = WIDTH / STAGES;
  logic [STAGES-1:0] r_v, r_c;
  logic [WIDTH-1:0]  r_a [STAGES];
  logic [WIDTH-1:0]  r_b [STAGES];
  logic [WIDTH-1:0]  r_s [STAGES];
  logic [STAGES-1:0] w_v, w_c, w_cn;
  logic [WIDTH-1:0]  w_a [STAGES];
  logic [WIDTH-1:0]  w_b [STAGES];
  logic [WIDTH-1:0]  w_s [STAGES];
  logic [WIDTH-1:0]  w_sn [STAGES];
  logic [CW:0]       w_add [STAGES];
  logic              w_stall;
  assign w_stall   = r_v[STAGES-1] & ~out_ready;
  assign in_ready  = ~w_stall;
  assign out_valid = r_v[STAGES-1];
  assign sum       = r_s[STAGES-1];
  assign cout      = r_c[STAGES-1];
  assign ovf       = (r_a[STAGES-1][WIDTH-1] == r_b[STAGES-1][WIDTH-1]) &
                     (r_s[STAGES-1][WIDTH-1] != r_a[STAGES-1][WIDTH-1]);
  // stage inputs (conditioned operands for stage 0, previous stage registers otherwise) and per-chunk add
  always_comb begin
    w_a[0] = a;
    w_b[0] = sub ? ~b : b;
    w_c[0] = sub ? ~cin : cin;
    w_s[0] = '0;
    w_v[0] = in_valid & in_ready;
    for (int k = 1; k < STAGES; k++) begin
      w_a[k] = r_a[k-1];
      w_b[k] = r_b[k-1];
      w_c[k] = r_c[k-1];
      w_s[k] = r_s[k-1];
      w_v[k] = r_v[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      w_add[k] = {1'b0, w_a[k][k*CW +: CW]} + {1'b0, w_b[k][k*CW +: CW]} + {{CW{1'b0}}, w_c[k]};
      w_sn[k] = w_s[k];
      w_sn[k][k*CW +: CW] = w_add[k][CW-1:0];
      w_cn[k] = w_add[k][CW];
    end
  end
  // pipeline registers advance together unless the output is stalled; data only loads on valid slots
  always_ff @(posedge clk)
    if (rst) begin
      r_v <= '0;
      r_c <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
      end
    end else if (!w_stall) begin
      r_v <= w_v;
      for (int k = 0; k < STAGES; k++)
        if (w_v[k]) begin
          r_a[k] <= w_a[k];
          r_b[k] <= w_b[k];
          r_s[k] <= w_sn[k];
          r_c[k] <= w_cn[k];
        end
    end
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: scoreboard bench for a 32-bit/4-stage and an 8-bit/1-stage adder/subtractor
module tb_pipelined_addsub;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, fails = 0;
  bit mon_en = 1;
  typedef struct { logic [31:0] s; logic c; logic o; int acc; bit lat; } exp_t;
  exp_t q32[$], q8[$];
  logic iv32 = 0, ir32, cin32 = 0, sub32 = 0, ov32, or32 = 1, co32, of32;
  logic [31:0] a32 = 0, b32 = 0, s32;
  logic iv8 = 0, ir8, cin8 = 0, sub8 = 0, ov8, or8 = 1, co8, of8;
  logic [7:0] a8 = 0, b8 = 0, s8;
  pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .cin(cin32), .sub(sub32),
    .out_valid(ov32), .out_ready(or32), .sum(s32), .cout(co32), .ovf(of32));
  pipelined_addsub #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .ovf(of8));
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  // reference built from wide signed/unsigned arithmetic: returns {ovf, cout, sum}
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic c, input logic s);
    longint sx, sy, ux, uy, rs, ru;
    logic co, ov;
    sx = longint'($signed(x)); sy = longint'($signed(y));
    ux = longint'({32'b0, x}); uy = longint'({32'b0, y});
    rs = s ? sx - sy - longint'(c) : sx + sy + longint'(c);
    ru = s ? ux - uy - longint'(c) : ux + uy + longint'(c);
    co = s ? (ru >= 0) : ru[32];
    ov = (rs > 64'sd2147483647) || (rs < -64'sd2147483648);
    return {ov, co, ru[31:0]};
  endfunction
  task automatic beat32(input logic [31:0] x, input logic [31:0] y, input logic c, input logic s,
                        input logic [31:0] es, input logic ec, input logic eo, input bit lat);
    bit ok = 0;
    a32 = x; b32 = y; cin32 = c; sub32 = s; iv32 = 1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = ir32;
      if (!ok) begin @(posedge clk); #1; end
    end
    if (ok) q32.push_back('{es, ec, eo, cyc, lat});
    else chk("accept32_timeout", 0, 1);
    @(posedge clk); #1;
    iv32 = 0;
  endtask
  task automatic beat8(input logic [7:0] x, input logic [7:0] y, input logic c, input logic s,
                       input logic [7:0] es, input logic ec, input logic eo);
    bit ok = 0;
    a8 = x; b8 = y; cin8 = c; sub8 = s; iv8 = 1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = ir8;
      if (!ok) begin @(posedge clk); #1; end
    end
    if (ok) q8.push_back('{{24'b0, es}, ec, eo, cyc, 1'b1});
    else chk("accept8_timeout", 0, 1);
    @(posedge clk); #1;
    iv8 = 0;
  endtask
  task automatic drain();
    for (int t = 0; t < 200 && (q32.size() != 0 || q8.size() != 0); t++) @(posedge clk);
    chk("drain_pending", 32'(q32.size() + q8.size()), 0);
    #1;
  endtask
  // monitor for the 32-bit instance: compares every presented result against the queue front
  always @(negedge clk)
    if (mon_en && !rst && ov32) begin
      if (q32.size() == 0) begin
        checks++; fails++;
        $display("FAIL out32_unexpected got sum=%h expected no output (cycle %0d)", s32, cyc);
      end else begin
        chk("sum32", s32, q32[0].s);
        chk("cout32", 32'(co32), 32'(q32[0].c));
        chk("ovf32", 32'(of32), 32'(q32[0].o));
        if (q32[0].lat && or32) chk("latency32", 32'(cyc - q32[0].acc), 4);
        if (or32) void'(q32.pop_front());
      end
    end
  // monitor for the 8-bit single-stage instance
  always @(negedge clk)
    if (!rst && ov8) begin
      if (q8.size() == 0) begin
        checks++; fails++;
        $display("FAIL out8_unexpected got sum=%h expected no output (cycle %0d)", s8, cyc);
      end else begin
        chk("sum8", 32'(s8), q8[0].s);
        chk("cout8", 32'(co8), 32'(q8[0].c));
        chk("ovf8", 32'(of8), 32'(q8[0].o));
        if (or8) chk("latency8", 32'(cyc - q8[0].acc), 1);
        if (or8) void'(q8.pop_front());
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    fails++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
  initial begin
    logic [33:0] m;
    logic [31:0] x, y;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_out_valid", 32'(ov32), 0);
    chk("reset_sum", s32, 0);
    chk("reset_cout", 32'(co32), 0);
    chk("reset_ovf", 32'(of32), 0);
    chk("reset_in_ready", 32'(ir32), 1);
    @(posedge clk); #1;
    beat8(8'hFF, 8'h01, 0, 0, 8'h00, 1, 0);
    beat8(8'h7F, 8'h01, 0, 0, 8'h80, 0, 1);
    beat32(32'hFFFF_FFFF, 32'h0, 1, 0, 32'h0, 1, 0, 1);
    drain();
    beat32(32'd5, 32'd7, 0, 1, 32'hFFFF_FFFE, 0, 0, 1);
    beat32(32'h8000_0000, 32'd1, 0, 1, 32'h7FFF_FFFF, 1, 1, 1);
    drain();
    for (int i = 0; i < 16; i++) beat32(32'(i), 32'hFFFF_FFFF, 0, 0, 32'(i - 1), i != 0, 0, 1);
    drain();
    fork
      for (int i = 0; i < 8; i++) begin
        x = 32'(i) * 32'h2000_0001;
        y = 32'h7000_0000 + 32'(i);
        m = model(x, y, i[1], i[0]);
        beat32(x, y, i[1], i[0], m[31:0], m[32], m[33], 0);
      end
      begin
        repeat (4) @(posedge clk);
        #1 or32 = 0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(ir32), 0);
          chk("stall_out_valid", 32'(ov32), 1);
        end
        @(posedge clk);
        #1 or32 = 1;
      end
    join
    drain();
    a32 = 32'h1111_1111; b32 = 32'h2222_2222; iv32 = 1;
    repeat (3) @(posedge clk);
    #1 iv32 = 0; rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("post_reset_out_valid", 32'(ov32), 0);
    repeat (6) @(posedge clk);
    #1;
    beat32(32'h0000_0010, 32'h0000_0020, 1, 0, 32'h0000_0031, 0, 0, 1);
    drain();
    mon_en = 0; or32 = 0; iv32 = 1;
    repeat (6) @(posedge clk);
    #1 iv32 = 0; rst = 1;
    @(posedge clk);
    #1 rst = 0; mon_en = 1;
    @(negedge clk);
    chk("stall_reset_in_ready", 32'(ir32), 1);
    chk("stall_reset_out_valid", 32'(ov32), 0);
    chk("stall_reset_sum", s32, 0);
    chk("stall_reset_flags", {30'b0, co32, of32}, 0);
    @(posedge clk);
    #1 or32 = 1;
    beat32(32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 32'h8000_0000, 0, 1, 1);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
